// File: rtl/key_entry_buf.sv
// key_entry_buf: debounces per-frame keypad hits from the row scanner and
// collects up to four accepted BCD digits, newest in the low nibble.
// A frame is one sel sweep 0..3; the FSM only advances on the sel==3 edge.
// Optional build macro KEY_REPEAT_EN: a key held in HELD re-accepts every
// REPEAT_FRAMES matching hit frames. Without it, one accept per press.
module key_entry_buf #(
    parameter int DEB_FRAMES = 3,
    parameter int REL_FRAMES = 2
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 16
`endif
) (
    input  logic        clk_sel,
    input  logic        rst,
    input  logic [2:0]  sel,
    input  logic        press,
    input  logic [3:0]  scan_code,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [2:0]  count,
    output logic        full,
    output logic        ovf
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEB,
        ST_HELD
    } state_t;

    state_t      state_q, state_d;
    logic        hit_q, hit_d;
    logic [3:0]  fcode_q, fcode_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [3:0]  rcnt_q, rcnt_d;
`ifdef KEY_REPEAT_EN
    logic [5:0]  pcnt_q, pcnt_d;
`endif
    logic        key_valid_q, key_valid_d;
    logic [3:0]  key_code_q, key_code_d;
    logic [15:0] digits_q, digits_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;

    logic        hit_now;
    logic        frame_end;
    logic        fr_hit;
    logic [3:0]  fr_code;
    logic        accept;

    // Frame hit tracking, debounce FSM and entry buffer next-state
    always_comb begin
        hit_now   = press && (sel <= 3'd3);
        frame_end = (sel == 3'd3);
        // the sel==3 cycle's own hit still belongs to the frame ending now
        fr_hit    = hit_q || hit_now;
        fr_code   = hit_q ? fcode_q : scan_code;

        state_d     = state_q;
        hit_d       = hit_q;
        fcode_d     = fcode_q;
        cand_d      = cand_q;
        dcnt_d      = dcnt_q;
        rcnt_d      = rcnt_q;
`ifdef KEY_REPEAT_EN
        pcnt_d      = pcnt_q;
`endif
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        digits_d    = digits_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        accept      = 1'b0;

        if (frame_end) begin
            hit_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fr_hit) begin
                        cand_d  = fr_code;
                        dcnt_d  = 4'd1;
                        state_d = ST_DEB;
                    end
                end
                ST_DEB: begin
                    if (!fr_hit) begin
                        dcnt_d  = 4'd0;
                        state_d = ST_IDLE;
                    end else if (fr_code == cand_q) begin
                        dcnt_d = dcnt_q + 4'd1;
                        if (dcnt_q + 4'd1 == 4'(DEB_FRAMES)) begin
                            accept  = 1'b1;
                            dcnt_d  = 4'd0;
                            rcnt_d  = 4'd0;
`ifdef KEY_REPEAT_EN
                            pcnt_d  = 6'd0;
`endif
                            state_d = ST_HELD;
                        end
                    end else begin
                        cand_d = fr_code;
                        dcnt_d = 4'd1;
                    end
                end
                ST_HELD: begin
                    if (fr_hit) begin
                        rcnt_d = 4'd0;
`ifdef KEY_REPEAT_EN
                        if (fr_code == cand_q) begin
                            if (pcnt_q + 6'd1 == 6'(REPEAT_FRAMES)) begin
                                accept = 1'b1;
                                pcnt_d = 6'd0;
                            end else begin
                                pcnt_d = pcnt_q + 6'd1;
                            end
                        end else begin
                            pcnt_d = 6'd0;
                        end
`endif
                    end else begin
`ifdef KEY_REPEAT_EN
                        pcnt_d = 6'd0;
`endif
                        if (rcnt_q + 4'd1 == 4'(REL_FRAMES)) begin
                            rcnt_d  = 4'd0;
                            state_d = ST_IDLE;
                        end else begin
                            rcnt_d = rcnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (hit_now && !hit_q) begin
            // first hit of the frame wins, i.e. the lowest scanned row
            hit_d   = 1'b1;
            fcode_d = scan_code;
        end

        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = cand_q;
        end

        // clear wins over a same-edge accept; the event itself still fires
        if (clr) begin
            digits_d = 16'hFFFF;
            count_d  = 3'd0;
            ovf_d    = 1'b0;
        end else if (accept) begin
            if (count_q < 3'd4) begin
                digits_d = {digits_q[11:0], cand_q};
                count_d  = count_q + 3'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers, asynchronous active-high reset
    always_ff @(posedge clk_sel or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hit_q       <= 1'b0;
            fcode_q     <= 4'd0;
            cand_q      <= 4'd0;
            dcnt_q      <= 4'd0;
            rcnt_q      <= 4'd0;
`ifdef KEY_REPEAT_EN
            pcnt_q      <= 6'd0;
`endif
            key_valid_q <= 1'b0;
            key_code_q  <= 4'hF;
            digits_q    <= 16'hFFFF;
            count_q     <= 3'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            fcode_q     <= fcode_d;
            cand_q      <= cand_d;
            dcnt_q      <= dcnt_d;
            rcnt_q      <= rcnt_d;
`ifdef KEY_REPEAT_EN
            pcnt_q      <= pcnt_d;
`endif
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digits    = digits_q;
    assign count     = count_q;
    assign full      = (count_q == 3'd4);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_entry_buf.sv
// Bench for key_entry_buf: drives whole scan frames (key on row 1), pushes
// the expected key event into a scoreboard when the accepting frame end is
// driven, and pops/compares whenever key_valid is seen.
module tb_key_entry_buf;

    localparam int DEB = 3;
    localparam int REP = 16;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic        clk_sel = 1'b0;
    logic        rst;
    logic [2:0]  sel;
    logic        press;
    logic [3:0]  scan_code;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        full;
    logic        ovf;

    key_entry_buf dut (
        .clk_sel   (clk_sel),
        .rst       (rst),
        .sel       (sel),
        .press     (press),
        .scan_code (scan_code),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digits    (digits),
        .count     (count),
        .full      (full),
        .ovf       (ovf)
    );

    always #5 clk_sel = ~clk_sel;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] digits;
        logic [2:0]  count;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        kv_prev = 1'b0;
    logic [15:0] m_digits = 16'hFFFF;
    logic [2:0]  m_count = 3'd0;
    logic        m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_sel) cyc <= cyc + 1;

    // Scoreboard consumer: every key_valid pulse must match the next expected event
    always @(negedge clk_sel) begin
        if (key_valid === 1'b1) begin
            check("kv_gap", 32'(kv_prev), 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("ev_cycle", 32'(cyc), 32'(e.cyc));
                check("ev_code", 32'(key_code), 32'(e.code));
                check("ev_digits", 32'(digits), 32'(e.digits));
                check("ev_count", 32'(count), 32'(e.count));
                check("ev_ovf", 32'(ovf), 32'(e.ovf));
                check("ev_full", 32'(full), 32'(e.count == 3'd4));
            end
        end
        kv_prev <= key_valid;
    end

    // Buffer model update plus scoreboard push for one accept
    task automatic push(input logic [3:0] code, input logic with_clr);
        exp_t x;
        if (with_clr) begin
            m_digits = 16'hFFFF;
            m_count  = 3'd0;
            m_ovf    = 1'b0;
        end else if (m_count < 3'd4) begin
            m_digits = {m_digits[11:0], code};
            m_count  = m_count + 3'd1;
        end else begin
            m_ovf = 1'b1;
        end
        x.code   = code;
        x.digits = m_digits;
        x.count  = m_count;
        x.ovf    = m_ovf;
        x.cyc    = cyc + 1;
        sbq.push_back(x);
    endtask

    task automatic do_frame(input logic hit, input logic [3:0] code, input logic clr_end,
                            input logic acc);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk_sel);
            sel       = 3'(s);
            press     = hit && (s == 1);
            scan_code = (hit && (s == 1)) ? code : 4'hA;
            clr       = clr_end && (s == 3);
            if (s == 3 && acc) push(code, clr_end);
        end
    endtask

    task automatic hold_key(input logic [3:0] code, input int n, input logic clr_last);
        logic acc;
        for (int f = 1; f <= n; f++) begin
            acc = (f == DEB) || (REP_EN && f > DEB && ((f - DEB) % REP) == 0);
            do_frame(1'b1, code, clr_last && (f == n), acc);
        end
    endtask

    task automatic release_frames(input int n);
        for (int f = 0; f < n; f++) do_frame(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_sel);
            sel   = 3'd4;
            press = 1'b0;
            clr   = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kv"}, 32'(key_valid), 32'd0);
        check({tag, "_code"}, 32'(key_code), 32'hF);
        check({tag, "_digits"}, 32'(digits), 32'hFFFF);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [5];
        seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7};
        rst = 1'b1; sel = 3'd4; press = 1'b0; scan_code = 4'h0; clr = 1'b0;
        repeat (2) @(negedge clk_sel);
        #1 check_reset_outputs("rst");
        @(negedge clk_sel);
        rst = 1'b0;
        idle(2);

        // single key 5, three frames
        hold_key(4'h5, 3, 1'b0);
        release_frames(2);
        idle(2);
        #1 check("k5_digits", 32'(digits), 32'hFFF5);
        check("k5_count", 32'(count), 32'd1);
        @(negedge clk_sel); clr = 1'b1;
        @(negedge clk_sel); clr = 1'b0;
        m_digits = 16'hFFFF; m_count = 3'd0; m_ovf = 1'b0;
        #1 check("clr_digits", 32'(digits), 32'hFFFF);
        check("clr_count", 32'(count), 32'd0);

        // bounce: never reaches three consecutive hit frames
        hold_key(4'h3, 2, 1'b0);
        release_frames(1);
        hold_key(4'h3, 2, 1'b0);
        release_frames(2);
        idle(2);
        #1 check("bounce_digits", 32'(digits), 32'hFFFF);
        check("bounce_count", 32'(count), 32'd0);

        // fill past capacity
        foreach (seq[i]) begin
            hold_key(seq[i], 3, 1'b0);
            release_frames(2);
        end
        idle(2);
        #1 check("fill_digits", 32'(digits), 32'h1234);
        check("fill_count", 32'(count), 32'd4);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ovf", 32'(ovf), 32'd1);
        check("fill_code", 32'(key_code), 32'h7);

        // clr on the accepting edge of key 8
        hold_key(4'h8, 3, 1'b1);
        release_frames(2);
        idle(2);
        #1 check("clracc_code", 32'(key_code), 32'h8);
        check("clracc_digits", 32'(digits), 32'hFFFF);
        check("clracc_count", 32'(count), 32'd0);
        check("clracc_ovf", 32'(ovf), 32'd0);

        // long hold of key 9
        hold_key(4'h9, 40, 1'b0);
        release_frames(2);
        idle(2);
        #1 check("hold_count", 32'(count), REP_EN ? 32'd3 : 32'd1);
        check("hold_digits", 32'(digits), REP_EN ? 32'hF999 : 32'hFFF9);

        // reset in the middle of debounce (dcnt=2), key still scanned
        hold_key(4'h6, 2, 1'b0);
        @(negedge clk_sel); sel = 3'd0; press = 1'b0;
        @(negedge clk_sel); sel = 3'd1; press = 1'b1; scan_code = 4'h6;
        @(negedge clk_sel); sel = 3'd2; press = 1'b0; rst = 1'b1;
        #1 check_reset_outputs("midrst");
        m_digits = 16'hFFFF; m_count = 3'd0; m_ovf = 1'b0;
        @(negedge clk_sel); rst = 1'b0; sel = 3'd3; press = 1'b0;
        hold_key(4'h6, 3, 1'b0);
        release_frames(2);
        idle(2);
        #1 check("midrst_digits", 32'(digits), 32'hFFF6);
        check("midrst_count", 32'(count), 32'd1);

        idle(4);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_entry_buf.md
# key_entry_buf

Debounces raw keypad hits and buffers up to four accepted digits. It sits directly downstream of the row scanner and key decoder, in the `clk_sel` domain. It consumes the per-cycle `press`/`scan_code` pair with the current row `sel`. It produces a one-cycle `key_valid` event and a 4-digit BCD entry register for display or compare logic.

## Interface
Parameters:
- DEB_FRAMES, 3, consecutive hit frames with identical code needed to accept a key (legal 2..15)
- REL_FRAMES, 2, consecutive no-hit frames needed to declare release (legal 1..15)
- REPEAT_FRAMES, 16, hit frames between auto-repeats (used only with KEY_REPEAT_EN; legal 2..63)

Ports:
- clk_sel  in  1  scan clock
- rst  in  1  reset, asynchronous, active-high
- sel  in  3  current scanned row, cycles 0,1,2,3
- press  in  1  decoder hit for this row/cycle
- scan_code  in  4  decoder code, valid when press=1
- clr  in  1  synchronous clear of the entry buffer
- key_valid  out  1  one-cycle pulse per accepted key
- key_code  out  4  last accepted digit
- digits  out  16  four BCD digits, newest in [3:0], unused nibbles 4'hF
- count  out  3  digits held, 0..4
- full  out  1  count==4 (combinational)
- ovf  out  1  sticky, a digit was rejected because the buffer was full

## Operation
- Frame = one sel sweep 0..3. Each cycle with press=1 and sel<=3 sets the frame hit flag. The first hit in a frame latches the frame code, so the lowest row wins.
- Frame end is the rising edge sampling sel==3, including any hit in that cycle. The FSM evaluates at that edge, and the hit flag clears there. sel in 4..7: no hit recorded, never a frame end.
- FSM states: IDLE, DEB, HELD.
  - IDLE: hit frame → cand=code, dcnt=1, go to DEB.
  - DEB:
    - hit with code==cand → dcnt+1; if dcnt reaches DEB_FRAMES, accept and go to HELD.
    - hit with a different code → cand=new code, dcnt=1.
    - no-hit frame → IDLE.
  - HELD:
    - hit frame (any code) → rcnt=0.
    - no-hit frame → rcnt+1; if rcnt reaches REL_FRAMES, go to IDLE.
    - A different key while HELD is ignored until release.
- Accept:
  - key_valid=1 and key_code=cand.
  - If count<4: digits={digits[11:0],cand} and count+1.
  - If count==4: digits and count unchanged, ovf=1.
- clr=1: digits=16'hFFFF, count=0, ovf=0. clr beats a simultaneous accept, but key_valid and key_code still update. clr does not affect the FSM.
- Reset values: key_valid=0, key_code=4'hF, digits=16'hFFFF, count=0, full=0, ovf=0, FSM=IDLE, all counters and flags 0. Reset mid-frame discards partial debounce state.

## Timing
- All outputs are registered except full.
- An accepting frame-end edge updates key_code, digits, count and ovf. key_valid is high for exactly the following cycle.
- Minimum press-to-event latency is DEB_FRAMES frames, i.e. DEB_FRAMES*4 clk_sel cycles from the first hit cycle's frame.
- Minimum release-to-rearm is REL_FRAMES frames.
- At most one accept per frame end; key_valid is never high in consecutive cycles.
- rst acts immediately, independent of clk_sel.

## Configuration
- KEY_REPEAT_EN defined: in HELD, consecutive hit frames whose code equals cand increment pcnt.
  - When pcnt reaches REPEAT_FRAMES, re-accept with identical buffer and ovf rules, and reset pcnt to 0.
  - A no-hit frame or a different code clears pcnt.
  - pcnt is 0 on entering HELD.
- Undefined: exactly one accept per press; pcnt logic and REPEAT_FRAMES are absent.

## Test plan
- Key 5 (sel=1, hit) held 3 frames from reset, defaults → one key_valid pulse after the 3rd frame end; key_code=5, digits=16'hFFF5, count=1.
- Bounce: 2 hit frames, 1 no-hit frame, 2 hit frames, release → no key_valid; digits stay 16'hFFFF.
- Enter 1,2,3,4,7, each held 3 frames and released 2 frames → 5 pulses; digits=16'h1234, count=4, full=1, ovf=1, key_code=7.
- clr asserted on the accepting edge of key 8 → key_valid pulses, key_code=8, digits=16'hFFFF, count=0, ovf=0.
- Hold key 9 for 40 frames, REPEAT_FRAMES=16 → without the macro, 1 pulse at frame 3. With KEY_REPEAT_EN, pulses at frames 3, 19 and 35.
- rst asserted mid-DEB (dcnt=2) for 1 cycle with the key still held → outputs at reset values. The next accept occurs only after 3 further full hit frames.
